// File: rtl/seq_scan_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_scan_ctrl_if : word-side valid/ready bundle for seq_scan_ctrl      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_scan_ctrl : word-to-serial shifter with overlapping 4-bit Mealy    |
// | pattern detector, saturating match counter and sticky threshold irq.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [3:0]       cfg_pattern,
    input  wire logic [CNT_W-1:0] cfg_thresh,
    seq_scan_ctrl_if.slave        word_if,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  match,
    output logic [CNT_W-1:0]      match_cnt,
    output logic                  irq,
    input  wire logic             irq_clr,
    output logic                  busy
);

    localparam int             IDX_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [3:0]         pat_q,   pat_d;
    logic [2:0]         hist_q,  hist_d;
    logic [1:0]         hcnt_q,  hcnt_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               irq_q,   irq_d;

    logic               last_bit;
    logic               ready;
    logic               accept;
    logic [CNT_W-1:0]   cnt_base;
    logic               irq_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            hist_q  <= '0;
            hcnt_q  <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            hcnt_q  <= hcnt_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    assign last_bit  = (idx_q == LAST_IDX);
    assign ready     = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last_bit);
    assign accept    = word_if.in_valid && ready;
    assign bit_valid = (state_q == ST_SHIFT);
    assign bit_out   = bit_valid && shift_q[WIDTH-1];
    assign busy      = bit_valid;
    assign match     = bit_valid && (hcnt_q == 2'd3) && ({hist_q, bit_out} == pat_q);

    assign word_if.in_ready = ready;
    assign match_cnt        = cnt_q;
    assign irq              = irq_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = word_if.in_data;
                    idx_d   = '0;
                    pat_d   = cfg_pattern;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_q << 1;
                idx_d   = idx_q + 1'b1;
                if (last_bit) begin
                    idx_d = '0;
                    if (accept) begin
                        shift_d = word_if.in_data;
                        pat_d   = cfg_pattern;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // History survives word boundaries and idle gaps so overlaps span words.
    always_comb begin
        hist_d = hist_q;
        hcnt_d = hcnt_q;
        if (bit_valid) begin
            hist_d = {hist_q[1:0], bit_out};
            if (hcnt_q != 2'd3) begin
                hcnt_d = hcnt_q + 2'd1;
            end
        end
    end

    // A clear zeroes the base first, so a coincident match lands at 1.
    always_comb begin
        cnt_base = irq_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (match && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
        irq_set = match && (cfg_thresh != '0) && (cnt_d == cfg_thresh);
        irq_d   = irq_set || (irq_q && !irq_clr);
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seq_scan_ctrl : directed vector bench for seq_scan_ctrl             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cfg_pattern = 4'h0;
    logic [7:0] cfg_thresh = 8'h0;
    logic [1:0] cfg_thresh2 = 2'h0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       irq_clr = 1'b0;

    logic       bit_out, bit_valid, match, irq, busy;
    logic [7:0] match_cnt;
    logic       bit_out2, bit_valid2, match2, irq2, busy2;
    logic [1:0] match_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    seq_scan_ctrl_if #(.WIDTH(8)) wif ();
    seq_scan_ctrl_if #(.WIDTH(8)) wif2 ();

    assign wif.in_valid  = in_valid;
    assign wif.in_data   = in_data;
    assign wif2.in_valid = in_valid;
    assign wif2.in_data  = in_data;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_pattern (cfg_pattern),
        .cfg_thresh  (cfg_thresh),
        .word_if     (wif.slave),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .match       (match),
        .match_cnt   (match_cnt),
        .irq         (irq),
        .irq_clr     (irq_clr),
        .busy        (busy)
    );

    seq_scan_ctrl #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .cfg_pattern (cfg_pattern),
        .cfg_thresh  (cfg_thresh2),
        .word_if     (wif2.slave),
        .bit_out     (bit_out2),
        .bit_valid   (bit_valid2),
        .match       (match2),
        .match_cnt   (match_cnt2),
        .irq         (irq2),
        .irq_clr     (irq_clr),
        .busy        (busy2)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] pat;
        logic [7:0] exp_match;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Accept one word from IDLE, then sample its WIDTH serial cycles.
    task automatic run_word(input logic [7:0] d, input logic [3:0] pat,
                            output logic [7:0] bits, output logic [7:0] mf,
                            output logic [7:0] vf, output logic [7:0] irqs,
                            output logic rdy_last);
        @(negedge clk);
        cfg_pattern = pat;
        in_valid    = 1'b1;
        in_data     = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bits[7-i] = bit_out;
            mf[7-i]   = match;
            vf[7-i]   = bit_valid;
            irqs[7-i] = irq;
        end
        rdy_last = wif.in_ready;
    endtask

    logic [7:0]  bits, mf, vf, irqs;
    logic        rdy_last, held;
    logic [15:0] bits16, mf16, vf16, busy16;

    initial begin
        vecs[0] = '{8'hDA, 4'b1101, 8'h12, 8'd2};
        vecs[1] = '{8'hFF, 4'b1111, 8'h1F, 8'd5};
        vecs[2] = '{8'h00, 4'b0000, 8'h1F, 8'd5};
        vecs[3] = '{8'hAA, 4'b1010, 8'h15, 8'd3};
        vecs[4] = '{8'hD0, 4'b1101, 8'h10, 8'd1};
        vecs[5] = '{8'h3C, 4'b0111, 8'h08, 8'd1};

        do_reset();
        #1;
        check("reset_in_ready",  32'(wif.in_ready), 32'd1);
        check("reset_bit_valid", 32'(bit_valid), 32'd0);
        check("reset_bit_out",   32'(bit_out), 32'd0);
        check("reset_busy",      32'(busy), 32'd0);
        check("reset_cnt_irq",   {23'd0, irq, match_cnt}, 32'd0);

        // Single-word table: each vector starts from a clean history.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            run_word(vecs[v].data, vecs[v].pat, bits, mf, vf, irqs, rdy_last);
            check($sformatf("vec%0d_bits", v),  32'(bits), 32'(vecs[v].data));
            check($sformatf("vec%0d_valid", v), 32'(vf), 32'hFF);
            check($sformatf("vec%0d_match", v), 32'(mf), 32'(vecs[v].exp_match));
            check($sformatf("vec%0d_ready", v), 32'(rdy_last), 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_cnt", v),   32'(match_cnt), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_idle", v),  {30'd0, bit_valid, irq}, 32'd0);
        end

        // Cross-word overlap, back-to-back 06 then 80.
        do_reset();
        @(negedge clk);
        cfg_pattern = 4'b1101;
        in_valid    = 1'b1;
        in_data     = 8'h06;
        @(posedge clk);
        #1 in_data = 8'h80;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bits16[15-i] = bit_out;
            mf16[15-i]   = match;
            vf16[15-i]   = bit_valid;
            busy16[15-i] = busy;
            if (i == 7) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        check("xword_bits",  32'(bits16), 32'h0680);
        check("xword_valid", 32'(vf16), 32'hFFFF);
        check("xword_busy",  32'(busy16), 32'hFFFF);
        check("xword_match", 32'(mf16), 32'h0080);
        @(posedge clk); #1;
        check("xword_cnt",   32'(match_cnt), 32'd1);

        // Threshold irq, hold through idle, then clear.
        do_reset();
        cfg_thresh = 8'd2;
        run_word(8'hDA, 4'b1101, bits, mf, vf, irqs, rdy_last);
        check("thr_irq_timing", 32'(irqs), 32'h01);
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            held = held & irq;
        end
        check("thr_irq_held", 32'(held), 32'd1);
        check("thr_cnt", 32'(match_cnt), 32'd2);
        @(negedge clk);
        irq_clr = 1'b1;
        @(posedge clk);
        #1 irq_clr = 1'b0;
        check("thr_clr_irq", 32'(irq), 32'd0);
        check("thr_clr_cnt", 32'(match_cnt), 32'd0);

        // Clear coincident with a match while threshold is 1.
        do_reset();
        cfg_thresh = 8'd1;
        @(negedge clk);
        cfg_pattern = 4'b1101;
        in_valid    = 1'b1;
        in_data     = 8'hDA;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 irq_clr = 1'b1;
        @(negedge clk);
        check("simul_match", 32'(match), 32'd1);
        check("simul_pre_cnt", 32'(match_cnt), 32'd1);
        @(posedge clk);
        #1 irq_clr = 1'b0;
        check("simul_cnt", 32'(match_cnt), 32'd1);
        check("simul_irq", 32'(irq), 32'd1);
        cfg_thresh = 8'd0;

        // Saturation on the narrow counter: three DA words, six matches.
        do_reset();
        for (int w = 0; w < 3; w++) begin
            run_word(8'hDA, 4'b1101, bits, mf, vf, irqs, rdy_last);
        end
        @(posedge clk); #1;
        check("sat_cnt2", 32'(match_cnt2), 32'd3);
        check("sat_cnt8", 32'(match_cnt), 32'd6);

        // Reset in the middle of FF, then D0 must match only at bit 3.
        do_reset();
        @(negedge clk);
        cfg_pattern = 4'b1101;
        in_valid    = 1'b1;
        in_data     = 8'hFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_pre_valid", 32'(bit_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(bit_valid), 32'd0);
        check("midrst_ready", 32'(wif.in_ready), 32'd1);
        check("midrst_cnt",   32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_word(8'hD0, 4'b1101, bits, mf, vf, irqs, rdy_last);
        check("midrst_d0_match", 32'(mf), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
